// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MULTU = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_DIVU  = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   // Widest value condNeg handles; callers zero-extend in and truncate out.
   localparam int NEG_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } muldiv_state_t;

   function automatic logic [NEG_W-1:0] condNeg(
      input logic [NEG_W-1:0] v,
      input logic             neg
   );
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             isDiv,
   input  logic [2*WIDTH:0] acc,
   input  logic [WIDTH-1:0] operand,
   output logic [2*WIDTH:0] accNext,
   output logic             qBit
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      sum     = acc[2*WIDTH:WIDTH]
              + (acc[0] ? {1'b0, operand} : '0);
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, operand};
      qBit    = 1'b0;
      accNext = {1'b0, sum, acc[WIDTH-1:1]};
      if (isDiv) begin
         // Remainder lives in the upper WIDTH+1 bits, quotient fills the low half.
         qBit    = ~diff[WIDTH+1];
         accNext = {qBit ? diff[WIDTH:0] : shifted,
                    acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers and start/busy/done handshake.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   muldiv_state_t state;

   logic             isDiv;
   logic             negRes;
   logic             negRem;
   logic             bZero;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] operand;
   logic [2*WIDTH:0] acc;
   logic [2*WIDTH:0] stepAcc;
   logic             qBit;

   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [2*WIDTH-1:0] prodRes;
   logic [WIDTH-1:0]   quoRes;
   logic [WIDTH-1:0]   remRes;

   muldiv_step #(.WIDTH(WIDTH)) step (
      .isDiv  (isDiv),
      .acc    (acc),
      .operand(operand),
      .accNext(stepAcc),
      .qBit   (qBit)
   );

   always_comb begin
      magA    = (op[0] && A[WIDTH-1]) ? -A : A;
      magB    = (op[0] && B[WIDTH-1]) ? -B : B;
      prodRes = (2*WIDTH)'(condNeg((NEG_W)'(acc[2*WIDTH-1:0]), negRes));
      // A zero divisor leaves the quotient all ones and the remainder equal to |A|,
      // so restoring the dividend sign yields the raw A.
      quoRes  = bZero ? acc[WIDTH-1:0]
              : (WIDTH)'(condNeg((NEG_W)'(acc[WIDTH-1:0]), negRes));
      remRes  = (WIDTH)'(condNeg((NEG_W)'(acc[2*WIDTH-1:WIDTH]), negRem));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         isDiv       <= 1'b0;
         negRes      <= 1'b0;
         negRem      <= 1'b0;
         bZero       <= 1'b0;
         cnt         <= '0;
         operand     <= '0;
         acc         <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  unique case (op)
                     OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                        isDiv       <= op[1];
                        negRes      <= op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
                        negRem      <= op[0] & A[WIDTH-1];
                        bZero       <= op[1] && (B == '0);
                        operand     <= op[1] ? magB : magA;
                        acc         <= {{(WIDTH+1){1'b0}}, op[1] ? magA : magB};
                        cnt         <= (CW)'(WIDTH);
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CALC;
                     end
                     OP_MTHI: begin
                        hi          <= A;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                     end
                     OP_MTLO: begin
                        lo          <= A;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            CALC: begin
               acc <= isDiv ? {stepAcc[2*WIDTH:1], qBit} : stepAcc;
               cnt <= cnt - (CW)'(1);
               if (cnt == (CW)'(1))
                  state <= FIX;
            end
            FIX: begin
               if (isDiv) begin
                  lo          <= quoRes;
                  hi          <= remRes;
                  div_by_zero <= bZero;
               end else begin
                  lo <= prodRes[WIDTH-1:0];
                  hi <= prodRes[2*WIDTH-1:WIDTH];
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
